branch_predict_pc_source: RTL and testbench

//  Next-generation PC-source controller for the pipelined core. Resolves

---
 rtl/branch_predict_pc_source.sv | 116 +++++++++++
 tb/tb_branch_predict_pc_source.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_pc_source.sv
// Resolves EX branches/jumps against a bimodal BHT and selects the next PC source.
// Latency: resolve and prediction are combinational, state updates at the edge; backpressure: none.
module branch_predict_pc_source #(
   parameter int PC_W      = 32,
   parameter int BHT_DEPTH = 16,
   parameter int CTR_W     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] fetch_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jump,
   input  logic            ex_jalr,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_pred_taken,
   input  logic [2:0]      f3,
   input  logic            zero,
   input  logic            lt,
   input  logic            ltu,
   output logic [1:0]      pc_src,
   output logic            flush,
   output logic            illegal_f3,
   input  logic            stats_clr,
   output logic [15:0]     branch_cnt,
   output logic [15:0]     mispred_cnt
);
   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

   typedef enum logic {ST_RUN, ST_SQUASH} state_t;

   state_t           state, state_nxt;
   logic [CTR_W-1:0] bht [BHT_DEPTH];
   logic [IDX_W-1:0] fetch_idx, ex_idx;
   logic             v, cond, bad_f3, counted, bht_we;
   logic             unused_pc_bits;

   assign fetch_idx  = fetch_pc[IDX_W+1:2];
   assign ex_idx     = ex_pc[IDX_W+1:2];
   assign pred_taken = bht[fetch_idx][CTR_W-1];
   assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                             ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Jump outranks branch, branch outranks jalr; the slot after any redirect is wrong-path.
   always_comb begin
      pc_src     = 2'b00;
      flush      = 1'b0;
      illegal_f3 = 1'b0;
      cond       = 1'b0;
      bad_f3     = 1'b0;
      counted    = 1'b0;
      bht_we     = 1'b0;
      v          = ex_valid && (state == ST_RUN);
      case (f3)
         3'b000:  cond = zero;
         3'b001:  cond = ~zero;
         3'b100:  cond = lt;
         3'b101:  cond = ~lt;
         3'b110:  cond = ltu;
         3'b111:  cond = ~ltu;
         default: bad_f3 = 1'b1;
      endcase
      if (v) begin
         illegal_f3 = ex_branch & bad_f3;
         if (ex_jump) begin
            pc_src = 2'b01;
            flush  = 1'b1;
         end else if (ex_branch) begin
            counted = 1'b1;
            bht_we  = ~bad_f3;
            if (cond != ex_pred_taken) begin
               flush  = 1'b1;
               pc_src = cond ? 2'b01 : 2'b11;
            end
         end else if (ex_jalr) begin
            pc_src = 2'b10;
            flush  = 1'b1;
         end
      end
      state_nxt = (v && flush) ? ST_SQUASH : ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
      end else if (bht_we) begin
         if (cond && (bht[ex_idx] != CTR_MAX))
            bht[ex_idx] <= bht[ex_idx] + CTR_W'(1);
         else if (!cond && (bht[ex_idx] != '0))
            bht[ex_idx] <= bht[ex_idx] - CTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (stats_clr) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (counted && (branch_cnt != 16'hFFFF))
            branch_cnt <= branch_cnt + 16'd1;
         if (counted && flush && (mispred_cnt != 16'hFFFF))
            mispred_cnt <= mispred_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_branch_predict_pc_source.sv
// Randomised and directed bench for branch_predict_pc_source against a behavioural model.
module tb_branch_predict_pc_source;
   logic        clk, rst_n;
   logic [31:0] fetch_pc, ex_pc;
   logic        pred_taken, ex_valid, ex_branch, ex_jump, ex_jalr, ex_pred_taken;
   logic [2:0]  f3;
   logic        zero, lt, ltu, flush, illegal_f3, stats_clr;
   logic [1:0]  pc_src;
   logic [15:0] branch_cnt, mispred_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int       m_bht [16];
   int       m_br, m_mp;
   bit       m_sq;
   logic [1:0] e_src;
   bit       e_flush, e_ill, e_upd, e_taken, e_cnt, e_v;

   branch_predict_pc_source dut (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
      .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .f3(f3), .zero(zero), .lt(lt),
      .ltu(ltu), .pc_src(pc_src), .flush(flush), .illegal_f3(illegal_f3),
      .stats_clr(stats_clr), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd15);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_bht[idx_of(pc)] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_br = 0;
      m_mp = 0;
      m_sq = 0;
   endtask

   function automatic void model_eval();
      bit illegal;
      e_src = 2'b00; e_flush = 0; e_ill = 0; e_upd = 0; e_taken = 0; e_cnt = 0;
      e_v = ex_valid && !m_sq;
      if (!e_v) return;
      illegal = ex_branch && (f3 == 3'd2 || f3 == 3'd3);
      e_ill = illegal;
      case (f3)
         3'd0: e_taken = zero;
         3'd1: e_taken = !zero;
         3'd4: e_taken = lt;
         3'd5: e_taken = !lt;
         3'd6: e_taken = ltu;
         3'd7: e_taken = !ltu;
         default: e_taken = 0;
      endcase
      if (ex_jump) begin
         e_src = 2'b01; e_flush = 1;
      end else if (ex_branch) begin
         e_cnt = 1;
         e_upd = !illegal;
         if (e_taken != ex_pred_taken) begin
            e_flush = 1;
            e_src = e_taken ? 2'b01 : 2'b11;
         end
      end else if (ex_jalr) begin
         e_src = 2'b10; e_flush = 1;
      end
   endfunction

   task automatic model_commit();
      int k;
      if (e_upd) begin
         k = idx_of(ex_pc);
         if (e_taken && m_bht[k] < 3) m_bht[k]++;
         else if (!e_taken && m_bht[k] > 0) m_bht[k]--;
      end
      if (stats_clr) begin
         m_br = 0; m_mp = 0;
      end else begin
         if (e_cnt && m_br < 65535) m_br++;
         if (e_cnt && e_flush && m_mp < 65535) m_mp++;
      end
      m_sq = e_v && e_flush;
   endtask

   task automatic drive(input bit vld, br, jmp, jr, input logic [31:0] pc, input bit pred,
                        input logic [2:0] fn, input bit z, l, lu);
      ex_valid = vld; ex_branch = br; ex_jump = jmp; ex_jalr = jr; ex_pc = pc;
      ex_pred_taken = pred; f3 = fn; zero = z; lt = l; ltu = lu;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 32'h0, 0, 3'd0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stats_clr = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 32'h0, 0, 3'd0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         fetch_pc = 32'(i * 4);
         #1;
         checks++;
         if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL reset_pred idx %0d: got %b expected 0", i, pred_taken);
         end
      end
      checks++;
      if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_cnts: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         fetch_pc = 32'(i * 4 + 32'h1000);
         #1;
         checks++;
         if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL post_reset_pred idx %0d: got %b expected 0", i, pred_taken);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_beq_mispredict();
      fetch_pc = 32'h40;
      drive(1, 1, 0, 0, 32'h40, 0, 3'd0, 1, 0, 0);
      checks++;
      if (pc_src !== 2'b01 || flush !== 1'b1) begin
         errors++; $display("FAIL beq_redirect: got src %0d flush %b expected 1 1", pc_src, flush);
      end
      tick();
      drive(1, 1, 0, 0, 32'h40, 0, 3'd0, 1, 0, 0);
      checks++;
      if (pc_src !== 2'b00 || flush !== 1'b0) begin
         errors++; $display("FAIL beq_squashed: got src %0d flush %b expected 0 0", pc_src, flush);
      end
      tick();
      idle();
      drive(1, 1, 0, 0, 32'h40, 0, 3'd0, 1, 0, 0);
      checks++;
      if (pc_src !== e_src || flush !== e_flush) begin
         errors++; $display("FAIL beq_reissue: got src %0d flush %b expected %0d %b", pc_src, flush, e_src, e_flush);
      end
      tick();
      idle();
      checks++;
      if (pred_taken !== 1'b1 || mispred_cnt !== 16'(m_mp) || branch_cnt !== 16'(m_br)) begin
         errors++; $display("FAIL beq_trained: got pred %b mp %0d br %0d expected 1 %0d %0d",
                            pred_taken, mispred_cnt, branch_cnt, m_mp, m_br);
      end
   endtask

   task automatic test_ctr_saturation();
      fetch_pc = 32'h40;
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 0, 32'h40, m_pred(32'h40), 3'd0, 1, 0, 0);
         tick();
         if (e_flush) idle();
      end
      drive(1, 1, 0, 0, 32'h40, 1, 3'd0, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b11 || flush !== 1'b1) begin
         errors++; $display("FAIL sat_recover: got src %0d flush %b expected 3 1", pc_src, flush);
      end
      tick();
      idle();
      checks++;
      if (pred_taken !== 1'b1 || m_bht[idx_of(32'h40)] != 2) begin
         errors++; $display("FAIL sat_after_nt: got pred %b expected 1 (model ctr %0d)", pred_taken, m_bht[idx_of(32'h40)]);
      end
   endtask

   task automatic test_f3_sweep();
      logic [31:0] pc;
      for (int i = 0; i < 8; i++) begin
         pc = 32'h200 + 32'(i * 4);
         fetch_pc = pc;
         drive(1, 1, 0, 0, pc, 0, 3'(i), 0, 1, 0);
         checks++;
         if (pc_src !== e_src || flush !== e_flush || illegal_f3 !== e_ill) begin
            errors++; $display("FAIL f3_%0d: got src %0d flush %b ill %b expected %0d %b %b",
                               i, pc_src, flush, illegal_f3, e_src, e_flush, e_ill);
         end
         tick();
         if (e_flush) idle();
         checks++;
         if (pred_taken !== m_pred(pc)) begin
            errors++; $display("FAIL f3_%0d_bht: got pred %b expected %b", i, pred_taken, m_pred(pc));
         end
      end
   endtask

   task automatic test_priority();
      int br0;
      drive(1, 1, 1, 1, 32'h300, 0, 3'd0, 1, 0, 0);
      checks++;
      if (pc_src !== 2'b01 || flush !== 1'b1) begin
         errors++; $display("FAIL prio_all: got src %0d flush %b expected 1 1", pc_src, flush);
      end
      tick();
      idle();
      br0 = m_br;
      drive(1, 0, 0, 1, 32'h304, 0, 3'd0, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b10 || flush !== 1'b1) begin
         errors++; $display("FAIL prio_jalr: got src %0d flush %b expected 2 1", pc_src, flush);
      end
      tick();
      idle();
      checks++;
      if (branch_cnt !== 16'(br0)) begin
         errors++; $display("FAIL jalr_no_count: got %0d expected %0d", branch_cnt, br0);
      end
   endtask

   task automatic test_stats_clr();
      drive(1, 1, 0, 0, 32'h340, 0, 3'd0, 1, 0, 0);
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      checks++;
      if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
         errors++; $display("FAIL stats_clr: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt);
      end
      idle();
   endtask

   task automatic test_random();
      logic [31:0] pc;
      bit vld, br, jmp, jr, pred;
      for (int n = 0; n < 400; n++) begin
         pc   = {$urandom_range(0, 255), 2'b00};
         vld  = $urandom_range(0, 3) != 0;
         br   = $urandom_range(0, 3) != 0;
         jmp  = $urandom_range(0, 9) == 0;
         jr   = $urandom_range(0, 7) == 0;
         pred = ($urandom_range(0, 4) == 0) ? bit'($urandom_range(0, 1)) : m_pred(pc);
         stats_clr = $urandom_range(0, 49) == 0;
         fetch_pc  = $urandom;
         drive(vld, br, jmp, jr, pc, pred, 3'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         checks++;
         if (pc_src !== e_src || flush !== e_flush || illegal_f3 !== e_ill || pred_taken !== m_pred(fetch_pc)) begin
            errors++; $display("FAIL rand_%0d: got src %0d flush %b ill %b pred %b expected %0d %b %b %b",
                               n, pc_src, flush, illegal_f3, pred_taken, e_src, e_flush, e_ill, m_pred(fetch_pc));
         end
         tick();
         checks++;
         if (branch_cnt !== 16'(m_br) || mispred_cnt !== 16'(m_mp)) begin
            errors++; $display("FAIL rand_cnt_%0d: got %0d/%0d expected %0d/%0d",
                               n, branch_cnt, mispred_cnt, m_br, m_mp);
         end
      end
      stats_clr = 1'b0;
      idle();
   endtask

   task automatic test_cnt_saturation();
      drive(1, 1, 0, 0, 32'h80, 0, 3'd0, 0, 0, 0);
      repeat (65540) tick();
      idle();
      checks++;
      if (branch_cnt !== 16'hFFFF || mispred_cnt !== 16'(m_mp)) begin
         errors++; $display("FAIL cnt_sat: got %h/%0d expected ffff/%0d", branch_cnt, mispred_cnt, m_mp);
      end
      drive(1, 1, 0, 0, 32'h80, 0, 3'd0, 0, 0, 0);
      tick();
      idle();
      checks++;
      if (branch_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_hold: got %h expected ffff", branch_cnt);
      end
   endtask

   task automatic test_async_reset();
      fetch_pc = 32'h40;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 32'h40, m_pred(32'h40), 3'd0, 1, 0, 0);
         tick();
         if (e_flush) idle();
      end
      drive(1, 0, 0, 1, 32'h44, 0, 3'd0, 0, 0, 0);
      checks++;
      if (pred_taken !== 1'b1 || flush !== 1'b1) begin
         errors++; $display("FAIL pre_async: got pred %b flush %b expected 1 1", pred_taken, flush);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (pred_taken !== 1'b0 || branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
         errors++; $display("FAIL async_reset: got pred %b cnt %0d/%0d expected 0 0/0",
                            pred_taken, branch_cnt, mispred_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 1, 32'h44, 0, 3'd0, 0, 0, 0);
      checks++;
      if (pc_src !== 2'b10 || flush !== 1'b1) begin
         errors++; $display("FAIL async_squash_cleared: got src %0d flush %b expected 2 1", pc_src, flush);
      end
      tick();
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      stats_clr = 1'b0;
      fetch_pc = 32'h0;
      test_reset();
      test_beq_mispredict();
      test_ctr_saturation();
      test_f3_sweep();
      test_priority();
      test_stats_clr();
      test_random();
      test_cnt_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
